// File: rtl/jtcommando_prom_we_if.sv
// jtcommando_prom_we_if: ROM-loader byte stream in, SDRAM programming and PROM write strobes out.
interface jtcommando_prom_we_if #(
   parameter int PROM_AW  = 8,
   parameter int PROM_NUM = 3
);
   logic                downloading;
   logic [21:0]         ioctl_addr;
   logic [7:0]          ioctl_data;
   logic                ioctl_wr;
   logic                sdram_ack;
   logic [21:0]         prog_addr;
   logic [7:0]          prog_data;
   logic [1:0]          prog_mask;
   logic                prog_we;
   logic [PROM_AW-1:0]  prom_addr;
   logic [7:0]          prom_din;
   logic [PROM_NUM-1:0] prom_we;
   logic                busy;
   logic                overflow;

   modport master (
      output downloading, ioctl_addr, ioctl_data, ioctl_wr, sdram_ack,
      input  prog_addr, prog_data, prog_mask, prog_we,
             prom_addr, prom_din, prom_we, busy, overflow
   );

   modport slave (
      input  downloading, ioctl_addr, ioctl_data, ioctl_wr, sdram_ack,
      output prog_addr, prog_data, prog_mask, prog_we,
             prom_addr, prom_din, prom_we, busy, overflow
   );
endinterface

// File: rtl/jtcommando_prom_we.sv
// jtcommando_prom_we: routes download bytes to SDRAM (two-entry ack-handshake buffer) or one-hot PROM strobes.
module jtcommando_prom_we #(
   parameter logic [21:0] PROM_START = 22'h50000,
   parameter int          PROM_AW    = 8,
   parameter int          PROM_NUM   = 3
) (
   input  logic                   clk,
   input  logic                   rst_n,
   jtcommando_prom_we_if.slave    io_bus
);
   localparam logic [22:0] PROM_END = {1'b0, PROM_START} + 23'(PROM_NUM << PROM_AW);

   typedef enum logic {IDLE, WAIT_ACK} state_t;

   state_t              r_state, w_state;
   logic [21:0]         r_addr, w_addr, r_t_addr, w_t_addr;
   logic [7:0]          r_data, w_data, r_t_data, w_t_data;
   logic [1:0]          r_mask, w_mask, r_t_mask, w_t_mask;
   logic                r_t_vld, w_t_vld, r_ovf, w_ovf;
   logic [PROM_AW-1:0]  r_prom_addr;
   logic [7:0]          r_prom_din;
   logic [PROM_NUM-1:0] r_prom_we, w_prom_we;
   logic                w_acc, w_lo, w_sd, w_prom;
   logic [21:0]         w_off, w_idx, w_n_addr;
   logic [1:0]          w_n_mask;

   assign w_acc     = io_bus.ioctl_wr & io_bus.downloading;
   assign w_lo      = io_bus.ioctl_addr < PROM_START;
   assign w_sd      = w_acc & w_lo;
   assign w_prom    = w_acc & ~w_lo & ({1'b0, io_bus.ioctl_addr} < PROM_END);
   assign w_off     = io_bus.ioctl_addr - PROM_START;
   assign w_idx     = w_off >> PROM_AW;
   assign w_prom_we = w_prom ? PROM_NUM'(1) << w_idx : '0;
   assign w_n_addr  = {1'b0, io_bus.ioctl_addr[21:1]};
   assign w_n_mask  = io_bus.ioctl_addr[0] ? 2'b01 : 2'b10;

   always_comb begin
      w_state  = r_state;
      w_addr   = r_addr;
      w_data   = r_data;
      w_mask   = r_mask;
      w_t_addr = r_t_addr;
      w_t_data = r_t_data;
      w_t_mask = r_t_mask;
      w_t_vld  = r_t_vld;
      w_ovf    = r_ovf;
      if (r_state == IDLE) begin
         if (w_sd) begin
            w_addr  = w_n_addr;
            w_data  = io_bus.ioctl_data;
            w_mask  = w_n_mask;
            w_state = WAIT_ACK;
         end
      end else if (io_bus.sdram_ack) begin
         // ack frees the head: the skid entry moves up, a new byte refills behind it
         if (r_t_vld) begin
            w_addr   = r_t_addr;
            w_data   = r_t_data;
            w_mask   = r_t_mask;
            w_t_vld  = w_sd;
            w_t_addr = w_n_addr;
            w_t_data = io_bus.ioctl_data;
            w_t_mask = w_n_mask;
         end else if (w_sd) begin
            w_addr = w_n_addr;
            w_data = io_bus.ioctl_data;
            w_mask = w_n_mask;
         end else begin
            w_state = IDLE;
         end
      end else if (w_sd) begin
         if (r_t_vld) begin
            w_ovf = 1'b1;
         end else begin
            w_t_vld  = 1'b1;
            w_t_addr = w_n_addr;
            w_t_data = io_bus.ioctl_data;
            w_t_mask = w_n_mask;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_addr      <= '0;
         r_data      <= '0;
         r_mask      <= 2'b11;
         r_t_addr    <= '0;
         r_t_data    <= '0;
         r_t_mask    <= 2'b11;
         r_t_vld     <= 1'b0;
         r_ovf       <= 1'b0;
         r_prom_addr <= '0;
         r_prom_din  <= '0;
         r_prom_we   <= '0;
      end else begin
         r_state   <= w_state;
         r_addr    <= w_addr;
         r_data    <= w_data;
         r_mask    <= w_mask;
         r_t_addr  <= w_t_addr;
         r_t_data  <= w_t_data;
         r_t_mask  <= w_t_mask;
         r_t_vld   <= w_t_vld;
         r_ovf     <= w_ovf;
         r_prom_we <= w_prom_we;
         if (w_prom) begin
            r_prom_addr <= io_bus.ioctl_addr[PROM_AW-1:0];
            r_prom_din  <= io_bus.ioctl_data;
         end
      end
   end

   assign io_bus.prog_addr = r_addr;
   assign io_bus.prog_data = r_data;
   assign io_bus.prog_mask = r_mask;
   assign io_bus.prog_we   = r_state == WAIT_ACK;
   assign io_bus.busy      = (r_state == WAIT_ACK) | r_t_vld;
   assign io_bus.overflow  = r_ovf;
   assign io_bus.prom_addr = r_prom_addr;
   assign io_bus.prom_din  = r_prom_din;
   assign io_bus.prom_we   = r_prom_we;
endmodule
